datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bus, register and RAM word width.
REQ-002 Parameter CONTROL_WIDTH, default 16: control word width; bit positions are the shared c_* constants.
REQ-003 Parameter RAM_DEPTH, default 16: program/data RAM words, addressed by a 4-bit MAR.
REQ-004 i_CLOCK_n  input  1  system clock; all state updates on its rising edge.
REQ-005 i_RESET  input  1  asynchronous, active-high reset.
REQ-006 i_CONTROL_SIGNALS  input  CONTROL_WIDTH  control word from the control unit, valid for the current T-cycle.
REQ-007 i_PROG_WE  input  1  program-load write strobe.
REQ-008 i_PROG_ADDR  input  4  program-load address.
REQ-009 i_PROG_DATA  input  DATA_WIDTH  program-load data.
REQ-010 o_IR_DATA  output  DATA_WIDTH/2  opcode, IR[7:4].
REQ-011 o_ZERO_FLAG, o_CARRY_FLAG  output  1 each  registered ALU flags.
REQ-012 o_OUT_DATA  output  DATA_WIDTH  output register contents.
REQ-013 o_OUT_VALID  output  1  one-cycle pulse after the OUT register loads.
REQ-014 o_HALTED  output  1  sticky halt indication.
REQ-015 o_BUS  output  DATA_WIDTH  current internal bus value (debug).
REQ-016 o_BUS_CONFLICT  output  1  sticky: more than one bus driver was asserted.

Function
REQ-017 Control bits (16): HALT, MAR_IN, RAM_IN, RAM_OUT, IR_IN, IR_OUT, A_IN, A_OUT, B_IN, ALU_OUT, ALU_SUB, OUT_IN, PC_INC, PC_OUT, JUMP, FLAGS_UPDATE.
REQ-018 Bus is combinational from pre-edge state. Drivers: PC_OUT (PC zero-extended), RAM_OUT (RAM[MAR]), IR_OUT (IR[3:0] zero-extended), A_OUT, ALU_OUT. No driver: bus = 0.
REQ-019 Multiple drivers: priority ALU_OUT > A_OUT > RAM_OUT > IR_OUT > PC_OUT; o_BUS_CONFLICT set at next edge and held until reset.
REQ-020 RAM read is asynchronous. A RAM_IN write stores the bus at RAM[MAR] on the edge.
REQ-021 i_PROG_WE writes i_PROG_DATA to RAM[i_PROG_ADDR] on the edge. It takes priority over RAM_IN, and is honoured during reset and halt.
REQ-022 ALU result is a 9-bit value. Add: A+B. Sub: A+~B+1. Bus takes result[7:0].
REQ-023 On FLAGS_UPDATE: carry <= result[8] (sub: 1 means no borrow, A>=B); zero <= (result[7:0]==0). Otherwise flags hold.
REQ-024 Any *_IN register loads the pre-edge bus. ALU_OUT|A_IN loads A with the sum computed from the old A.
REQ-025 MAR and PC load bus[3:0]. PC_INC increments PC modulo 16 (15 -> 0). JUMP loads PC. JUMP with PC_INC in the same cycle: JUMP wins.
REQ-026 OUT_IN loads the OUT register; o_OUT_VALID is 1 for exactly the following cycle.
REQ-027 HALT sets the halted state on the edge. While halted, all register, flag and RAM_IN updates are suppressed, o_OUT_VALID is 0, and only reset or i_PROG_WE take effect.
REQ-028 States: RUN, HALTED. RUN->HALTED on HALT. HALTED->RUN only on reset.

Reset
REQ-029 Asserting i_RESET immediately forces PC, MAR, IR, A, B, OUT to 0, both flags to 0, and o_OUT_VALID, o_HALTED, o_BUS_CONFLICT to 0. State returns to RUN.
REQ-030 RAM contents are not reset. Reset asserted mid-operation discards any edge-coincident control word.
REQ-031 First edge after deassertion executes the control word presented then.

Structure
REQ-032 The c_* control bit constants and CONTROL_WIDTH live in the shared control-signal include, also used by the control unit.
REQ-033 One sub-module, alu: combinational add/sub producing 8-bit result plus carry and zero, instantiated once.

Verification
REQ-034 Load RAM[14]=0x05, RAM[15]=0x03. Run LDA 14 control sequence -> A=0x05, o_IR_DATA=1.
REQ-035 A=0x05, B=0x03, ALU_OUT|A_IN|FLAGS_UPDATE|ALU_SUB -> A=0x02, carry=1, zero=0. Repeat with B=0x02 -> A=0x00, zero=1, carry=1.
REQ-036 A=0xFF, B=0x01, add with FLAGS_UPDATE -> A=0x00, carry=1, zero=1. Same without FLAGS_UPDATE -> flags unchanged.
REQ-037 PC=15, PC_INC -> PC=0. PC=3, PC_INC|JUMP|IR_OUT with IR=0x8A -> PC=0xA.
REQ-038 A_OUT|OUT_IN with A=0x2A -> o_OUT_DATA=0x2A, o_OUT_VALID high one cycle. Then HALT -> o_HALTED=1 and A_IN with bus 0x11 is ignored. Reset -> all outputs 0, RAM retained.
REQ-039 A_OUT|RAM_OUT together -> bus=A, o_BUS_CONFLICT=1 until reset.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared control-word bit positions and datapath state encoding.
// The control unit imports the same constants so both sides agree on the word layout.
package datapath_pkg;

  localparam int unsigned CONTROL_WIDTH = 16;

  localparam int unsigned c_halt         = 0;
  localparam int unsigned c_mar_in       = 1;
  localparam int unsigned c_ram_in       = 2;
  localparam int unsigned c_ram_out      = 3;
  localparam int unsigned c_ir_in        = 4;
  localparam int unsigned c_ir_out       = 5;
  localparam int unsigned c_a_in         = 6;
  localparam int unsigned c_a_out        = 7;
  localparam int unsigned c_b_in         = 8;
  localparam int unsigned c_alu_out      = 9;
  localparam int unsigned c_alu_sub      = 10;
  localparam int unsigned c_out_in       = 11;
  localparam int unsigned c_pc_inc       = 12;
  localparam int unsigned c_pc_out       = 13;
  localparam int unsigned c_jump         = 14;
  localparam int unsigned c_flags_update = 15;

  typedef enum logic {StRun, StHalted} dp_state_e;

endpackage

// File: rtl/datapath_if.sv
// Control, program-load and status signals between the control unit (master) and datapath.
interface datapath_if #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned CONTROL_WIDTH = 16
);
  logic [CONTROL_WIDTH-1:0] i_CONTROL_SIGNALS;
  logic                     i_PROG_WE;
  logic [3:0]               i_PROG_ADDR;
  logic [DATA_WIDTH-1:0]    i_PROG_DATA;
  logic [DATA_WIDTH/2-1:0]  o_IR_DATA;
  logic                     o_ZERO_FLAG;
  logic                     o_CARRY_FLAG;
  logic [DATA_WIDTH-1:0]    o_OUT_DATA;
  logic                     o_OUT_VALID;
  logic                     o_HALTED;
  logic [DATA_WIDTH-1:0]    o_BUS;
  logic                     o_BUS_CONFLICT;

  modport master (
    output i_CONTROL_SIGNALS, i_PROG_WE, i_PROG_ADDR, i_PROG_DATA,
    input  o_IR_DATA, o_ZERO_FLAG, o_CARRY_FLAG, o_OUT_DATA, o_OUT_VALID, o_HALTED,
    input  o_BUS, o_BUS_CONFLICT
  );

  modport slave (
    input  i_CONTROL_SIGNALS, i_PROG_WE, i_PROG_ADDR, i_PROG_DATA,
    output o_IR_DATA, o_ZERO_FLAG, o_CARRY_FLAG, o_OUT_DATA, o_OUT_VALID, o_HALTED,
    output o_BUS, o_BUS_CONFLICT
  );
endinterface

// File: rtl/datapath_alu.sv
// Combinational adder/subtractor; subtraction is A + ~B + 1 so carry=1 means no borrow.
module alu #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  sub_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  carry_o,
  output logic                  zero_o
);
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] b_op;

  always_comb begin
    b_op     = sub_i ? ~b_i : b_i;
    sum      = {1'b0, a_i} + {1'b0, b_op} + {{DATA_WIDTH{1'b0}}, sub_i};
    result_o = sum[DATA_WIDTH-1:0];
    carry_o  = sum[DATA_WIDTH];
    zero_o   = (sum[DATA_WIDTH-1:0] == '0);
  end
endmodule

// File: rtl/datapath.sv
// SAP-style datapath: shared bus, PC/MAR/IR/A/B/OUT registers, RAM, ALU flags and halt state.
module datapath #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned CONTROL_WIDTH = datapath_pkg::CONTROL_WIDTH,
  parameter int unsigned RAM_DEPTH     = 16
) (
  input  logic      i_CLOCK_n,
  input  logic      i_RESET,
  datapath_if.slave bus_if
);
  import datapath_pkg::*;

  logic [CONTROL_WIDTH-1:0] ctrl;
  logic [DATA_WIDTH-1:0]    mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0]    bus, alu_res;
  logic                     alu_carry, alu_zero;
  logic [2:0]               n_drv;
  dp_state_e                state_q, state_d;
  logic [3:0]               pc_q, pc_d, mar_q, mar_d;
  logic [DATA_WIDTH-1:0]    ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
  logic                     zero_q, zero_d, carry_q, carry_d;
  logic                     out_valid_q, out_valid_d, conflict_q, conflict_d;

  assign ctrl = bus_if.i_CONTROL_SIGNALS;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .sub_i    (ctrl[c_alu_sub]),
    .result_o (alu_res),
    .carry_o  (alu_carry),
    .zero_o   (alu_zero)
  );

  // Bus priority: ALU > A > RAM > IR > PC.
  always_comb begin
    bus = '0;
    if      (ctrl[c_alu_out]) bus = alu_res;
    else if (ctrl[c_a_out])   bus = a_q;
    else if (ctrl[c_ram_out]) bus = mem[mar_q];
    else if (ctrl[c_ir_out])  bus = DATA_WIDTH'(ir_q[3:0]);
    else if (ctrl[c_pc_out])  bus = DATA_WIDTH'(pc_q);
    n_drv = {2'b00, ctrl[c_alu_out]} + {2'b00, ctrl[c_a_out]} + {2'b00, ctrl[c_ram_out]}
          + {2'b00, ctrl[c_ir_out]} + {2'b00, ctrl[c_pc_out]};
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mar_d       = mar_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    out_d       = out_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    out_valid_d = 1'b0;
    conflict_d  = conflict_q;
    if (state_q == StRun) begin
      if (ctrl[c_halt])   state_d = StHalted;
      if (ctrl[c_mar_in]) mar_d = bus[3:0];
      if (ctrl[c_ir_in])  ir_d = bus;
      if (ctrl[c_a_in])   a_d = bus;
      if (ctrl[c_b_in])   b_d = bus;
      if (ctrl[c_out_in]) out_d = bus;
      if (ctrl[c_jump])        pc_d = bus[3:0];
      else if (ctrl[c_pc_inc]) pc_d = pc_q + 4'd1;
      if (ctrl[c_flags_update]) begin
        carry_d = alu_carry;
        zero_d  = alu_zero;
      end
      // No pulse if the same word halts, since halted must read as invalid.
      out_valid_d = ctrl[c_out_in] & ~ctrl[c_halt];
      if (n_drv > 3'd1) conflict_d = 1'b1;
    end
  end

  always_ff @(posedge i_CLOCK_n or posedge i_RESET) begin
    if (i_RESET) begin
      state_q     <= StRun;
      pc_q        <= '0;
      mar_q       <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      conflict_q  <= conflict_d;
    end
  end

  // RAM is not reset; program loads work even in reset or halt.
  always_ff @(posedge i_CLOCK_n) begin
    if (bus_if.i_PROG_WE) begin
      mem[bus_if.i_PROG_ADDR] <= bus_if.i_PROG_DATA;
    end else if (!i_RESET && state_q == StRun && ctrl[c_ram_in]) begin
      mem[mar_q] <= bus;
    end
  end

  assign bus_if.o_IR_DATA      = ir_q[DATA_WIDTH-1:DATA_WIDTH/2];
  assign bus_if.o_ZERO_FLAG    = zero_q;
  assign bus_if.o_CARRY_FLAG   = carry_q;
  assign bus_if.o_OUT_DATA     = out_q;
  assign bus_if.o_OUT_VALID    = out_valid_q;
  assign bus_if.o_HALTED       = (state_q == StHalted);
  assign bus_if.o_BUS          = bus;
  assign bus_if.o_BUS_CONFLICT = conflict_q;
endmodule

// File: tb/tb_datapath.sv
// Directed-vector bench for datapath: LDA, ALU add/sub flags, PC wrap/jump, OUT, halt, conflict.
module tb_datapath;
  import datapath_pkg::*;

  localparam logic [15:0] Halt   = 16'd1 << c_halt;
  localparam logic [15:0] MarIn  = 16'd1 << c_mar_in;
  localparam logic [15:0] RamIn  = 16'd1 << c_ram_in;
  localparam logic [15:0] RamOut = 16'd1 << c_ram_out;
  localparam logic [15:0] IrIn   = 16'd1 << c_ir_in;
  localparam logic [15:0] IrOut  = 16'd1 << c_ir_out;
  localparam logic [15:0] AIn    = 16'd1 << c_a_in;
  localparam logic [15:0] AOut   = 16'd1 << c_a_out;
  localparam logic [15:0] BIn    = 16'd1 << c_b_in;
  localparam logic [15:0] AluOut = 16'd1 << c_alu_out;
  localparam logic [15:0] AluSub = 16'd1 << c_alu_sub;
  localparam logic [15:0] OutIn  = 16'd1 << c_out_in;
  localparam logic [15:0] PcInc  = 16'd1 << c_pc_inc;
  localparam logic [15:0] PcOut  = 16'd1 << c_pc_out;
  localparam logic [15:0] Jump   = 16'd1 << c_jump;
  localparam logic [15:0] FlUpd  = 16'd1 << c_flags_update;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [3:0] mar_m = 4'd0;

  datapath_if #(.DATA_WIDTH(8), .CONTROL_WIDTH(16)) dp_if ();

  datapath #(.DATA_WIDTH(8), .CONTROL_WIDTH(16), .RAM_DEPTH(16)) u_dut (
    .i_CLOCK_n (clk),
    .i_RESET   (rst),
    .bus_if    (dp_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [15:0] c);
    dp_if.i_CONTROL_SIGNALS = c;
    @(posedge clk);
    #1;
    dp_if.i_CONTROL_SIGNALS = '0;
  endtask

  task automatic prog(input logic [3:0] addr, input logic [7:0] data);
    dp_if.i_PROG_WE   = 1'b1;
    dp_if.i_PROG_ADDR = addr;
    dp_if.i_PROG_DATA = data;
    @(posedge clk);
    #1;
    dp_if.i_PROG_WE = 1'b0;
  endtask

  // Drive a control word mid-cycle and sample the combinational bus.
  task automatic peek(input string tag, input logic [15:0] c, input logic [7:0] exp);
    @(negedge clk);
    dp_if.i_CONTROL_SIGNALS = c;
    #1;
    check(tag, 16'(dp_if.o_BUS), 16'(exp));
    dp_if.i_CONTROL_SIGNALS = '0;
  endtask

  task automatic put(input logic [7:0] v, input logic [15:0] c);
    prog(mar_m, v);
    step(RamOut | c);
  endtask

  task automatic set_mar(input logic [3:0] a);
    prog(mar_m, 8'(a));
    step(RamOut | MarIn);
    mar_m = a;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ir"},   16'(dp_if.o_IR_DATA), 16'h0);
    check({tag, "_z"},    16'(dp_if.o_ZERO_FLAG), 16'h0);
    check({tag, "_c"},    16'(dp_if.o_CARRY_FLAG), 16'h0);
    check({tag, "_out"},  16'(dp_if.o_OUT_DATA), 16'h0);
    check({tag, "_vld"},  16'(dp_if.o_OUT_VALID), 16'h0);
    check({tag, "_halt"}, 16'(dp_if.o_HALTED), 16'h0);
    check({tag, "_conf"}, 16'(dp_if.o_BUS_CONFLICT), 16'h0);
    check({tag, "_bus"},  16'(dp_if.o_BUS), 16'h0);
  endtask

  initial begin
    dp_if.i_CONTROL_SIGNALS = '0;
    dp_if.i_PROG_WE         = 1'b0;
    dp_if.i_PROG_ADDR       = '0;
    dp_if.i_PROG_DATA       = '0;
    // Program load while reset is held.
    prog(4'd0, 8'h1E);
    prog(4'd14, 8'h05);
    prog(4'd15, 8'h03);
    check_reset_outputs("rst0");
    @(negedge clk);
    rst = 1'b0;

    // LDA 14
    step(PcOut | MarIn);
    step(RamOut | IrIn | PcInc);
    step(IrOut | MarIn);
    step(RamOut | AIn);
    mar_m = 4'd14;
    check("lda_ir", 16'(dp_if.o_IR_DATA), 16'h1);
    peek("lda_a", AOut, 8'h05);
    peek("lda_pc", PcOut, 8'h01);

    // Subtract: 5-3, then 2-2
    set_mar(4'd12);
    put(8'h03, BIn);
    peek("sub1_bus", AluOut | AluSub, 8'h02);
    step(AluOut | AIn | FlUpd | AluSub);
    peek("sub1_a", AOut, 8'h02);
    check("sub1_c", 16'(dp_if.o_CARRY_FLAG), 16'h1);
    check("sub1_z", 16'(dp_if.o_ZERO_FLAG), 16'h0);
    put(8'h02, BIn);
    step(AluOut | AIn | FlUpd | AluSub);
    peek("sub2_a", AOut, 8'h00);
    check("sub2_c", 16'(dp_if.o_CARRY_FLAG), 16'h1);
    check("sub2_z", 16'(dp_if.o_ZERO_FLAG), 16'h1);

    // Add with overflow; then add without flag update (0x10+1 would clear both)
    put(8'h05, AIn);
    put(8'h03, BIn);
    step(AluOut | AIn | FlUpd | AluSub);
    put(8'hFF, AIn);
    put(8'h01, BIn);
    step(AluOut | AIn | FlUpd);
    peek("add1_a", AOut, 8'h00);
    check("add1_c", 16'(dp_if.o_CARRY_FLAG), 16'h1);
    check("add1_z", 16'(dp_if.o_ZERO_FLAG), 16'h1);
    put(8'h10, AIn);
    step(AluOut | AIn);
    peek("add2_a", AOut, 8'h11);
    check("add2_c", 16'(dp_if.o_CARRY_FLAG), 16'h1);
    check("add2_z", 16'(dp_if.o_ZERO_FLAG), 16'h1);

    // PC wrap and jump-over-increment
    put(8'h0F, Jump);
    peek("pc15", PcOut, 8'h0F);
    step(PcInc);
    peek("pc_wrap", PcOut, 8'h00);
    put(8'h03, Jump);
    put(8'h8A, IrIn);
    check("ir_op", 16'(dp_if.o_IR_DATA), 16'h8);
    peek("ir_out", IrOut, 8'h0A);
    step(PcInc | Jump | IrOut);
    peek("pc_jump", PcOut, 8'h0A);

    // OUT register and valid pulse
    put(8'h2A, AIn);
    step(AOut | OutIn);
    check("out_data", 16'(dp_if.o_OUT_DATA), 16'h2A);
    check("out_vld1", 16'(dp_if.o_OUT_VALID), 16'h1);
    step(16'h0);
    check("out_vld0", 16'(dp_if.o_OUT_VALID), 16'h0);
    check("out_hold", 16'(dp_if.o_OUT_DATA), 16'h2A);

    // Halt: register loads suppressed, program loads still honoured
    step(Halt);
    check("halted", 16'(dp_if.o_HALTED), 16'h1);
    put(8'h11, AIn);
    peek("halt_a", AOut, 8'h2A);
    peek("halt_prog", RamOut, 8'h11);
    step(AOut | OutIn);
    check("halt_vld", 16'(dp_if.o_OUT_VALID), 16'h0);
    check("halt_stay", 16'(dp_if.o_HALTED), 16'h1);

    // Asynchronous reset mid-cycle
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst1");
    @(negedge clk);
    rst = 1'b0;
    mar_m = 4'd0;
    peek("rst_a", AOut, 8'h00);
    set_mar(4'd15);
    peek("ram_keep", RamOut, 8'h03);

    // Bus conflict, then RAM_IN write-back
    put(8'h77, AIn);
    prog(4'd15, 8'h33);
    peek("conf_bus", AOut | RamOut, 8'h77);
    check("conf_pre", 16'(dp_if.o_BUS_CONFLICT), 16'h0);
    step(AOut | RamOut);
    check("conf_set", 16'(dp_if.o_BUS_CONFLICT), 16'h1);
    step(AOut | RamIn);
    check("conf_hold", 16'(dp_if.o_BUS_CONFLICT), 16'h1);
    peek("ram_in", RamOut, 8'h77);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("conf_rst", 16'(dp_if.o_BUS_CONFLICT), 16'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
